// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the I-fetch and D load/store requesters one combinational-read memory port.
// Response pulses WAIT_CYCLES+1 cycles after the handshake, no response back-pressure; MEM_ARB_PERF_EN adds perf counters.
module mem_arbiter #(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req_valid,
   output logic              i_req_ready,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_resp_valid,
   output logic [31:0]       i_rdata,
   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [3:0]        d_wstrb,
   output logic              d_resp_valid,
   output logic [31:0]       d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   output logic              mem_wen,
   input  logic [31:0]       mem_rdata
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]       perf_i_grants,
   output logic [31:0]       perf_d_grants,
   output logic [31:0]       perf_conflicts
`endif
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic [3:0]        wstrb;
      logic              owner_d;
   } req_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             last_d;
   req_t             req;
   logic             i_hs, d_hs, last_acc;

   assign i_hs     = i_req_valid & i_req_ready;
   assign d_hs     = d_req_valid & d_req_ready;
   assign last_acc = (state == ACCESS) && (cnt == '0);

   assign mem_addr  = req.addr & ~ADDR_W'(3);
   assign mem_wdata = req.wdata;
   assign mem_wstrb = req.wstrb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      i_req_ready = 1'b0;
      d_req_ready = 1'b0;
      mem_wen     = 1'b0;
      case (state)
         IDLE: begin
            // On conflict the requester that did not win last time goes first.
            if (i_req_valid && d_req_valid) begin
               i_req_ready = last_d;
               d_req_ready = ~last_d;
            end else begin
               i_req_ready = i_req_valid;
               d_req_ready = d_req_valid;
            end
            if (i_req_valid || d_req_valid) state_nxt = ACCESS;
         end
         ACCESS: begin
            mem_wen = last_acc && (req.wstrb != 4'b0);
            if (cnt == '0) state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         last_d       <= 1'b0;
         req          <= '0;
         i_rdata      <= '0;
         d_rdata      <= '0;
         i_resp_valid <= 1'b0;
         d_resp_valid <= 1'b0;
      end else begin
         i_resp_valid <= last_acc & ~req.owner_d;
         d_resp_valid <= last_acc & req.owner_d;
         if (i_hs || d_hs) begin
            req.addr    <= d_hs ? d_addr  : i_addr;
            req.wdata   <= d_hs ? d_wdata : 32'h0;
            req.wstrb   <= d_hs ? d_wstrb : 4'h0;
            req.owner_d <= d_hs;
            last_d      <= d_hs;
            cnt         <= CNT_LOAD;
         end else if (state == ACCESS && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (last_acc) begin
            if (req.owner_d) d_rdata <= (req.wstrb != 4'b0) ? 32'h0 : mem_rdata;
            else             i_rdata <= mem_rdata;
         end
      end
   end

`ifdef MEM_ARB_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_i_grants  <= '0;
         perf_d_grants  <= '0;
         perf_conflicts <= '0;
      end else begin
         if (i_hs) perf_i_grants <= perf_i_grants + 32'd1;
         if (d_hs) perf_d_grants <= perf_d_grants + 32'd1;
         if (state == IDLE && i_req_valid && d_req_valid)
            perf_conflicts <= perf_conflicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a cycle-schedule reference model and a byte-strobed memory.
module tb_mem_arbiter;
   localparam int W = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req_valid = 1'b0, d_req_valid = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic [3:0]  d_wstrb = '0;
   logic        i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, mem_wen;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts;
`endif

   mem_arbiter #(.WAIT_CYCLES(W), .ADDR_W(32)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
      .i_resp_valid(i_resp_valid), .i_rdata(i_rdata),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_wen(mem_wen), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
      , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
      .perf_conflicts(perf_conflicts)
`endif
   );

   always #5 clk = ~clk;

   logic [31:0] mem [256];
   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk)
      if (mem_wen)
         for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];

   int checks = 0, failures = 0, cyc = 0;
   int free_at, hs_cyc, n_ig, n_dg, n_conf;
   bit last_d, txn_active, t_d, t_write;
   logic [31:0] t_addr, t_wdata, t_rdata, exp_i_rdata, exp_d_rdata;
   logic [3:0]  t_wstrb;
   logic [31:0] ref_mem [256];

   function automatic logic [31:0] init_val(input int k);
      return (32'(k) * 32'h0103_0507) ^ 32'h5A5A_A5A5;
   endfunction

   function automatic logic [31:0] rand_addr();
      return ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // Model: one access in flight; handshake at N, last access cycle N+W, response N+W+1, free at N+W+2.
   task automatic check_cycle();
      logic er_i, er_d, e_wen, e_ir, e_dr;
      er_i = 1'b0;
      er_d = 1'b0;
      if (cyc >= free_at) begin
         if (i_req_valid && d_req_valid) begin
            n_conf++;
            er_i = last_d;
            er_d = !last_d;
         end else begin
            er_i = i_req_valid;
            er_d = d_req_valid;
         end
      end
      check_eq("i_req_ready", 32'(i_req_ready), 32'(er_i));
      check_eq("d_req_ready", 32'(d_req_ready), 32'(er_d));

      e_wen = txn_active && t_write && (cyc == hs_cyc + W);
      check_eq("mem_wen", 32'(mem_wen), 32'(e_wen));
      if (txn_active && cyc > hs_cyc && cyc <= hs_cyc + W) begin
         check_eq("mem_addr", mem_addr, t_addr & ~32'h3);
         check_eq("mem_wstrb", 32'(mem_wstrb), 32'(t_wstrb));
         if (t_d) check_eq("mem_wdata", mem_wdata, t_wdata);
      end
      if (e_wen)
         for (int b = 0; b < 4; b++)
            if (t_wstrb[b]) ref_mem[t_addr[9:2]][8*b +: 8] = t_wdata[8*b +: 8];

      e_ir = txn_active && !t_d && (cyc == hs_cyc + W + 1);
      e_dr = txn_active &&  t_d && (cyc == hs_cyc + W + 1);
      if (e_ir) exp_i_rdata = t_rdata;
      if (e_dr) exp_d_rdata = t_rdata;
      if (e_ir || e_dr) txn_active = 1'b0;
      check_eq("i_resp_valid", 32'(i_resp_valid), 32'(e_ir));
      check_eq("d_resp_valid", 32'(d_resp_valid), 32'(e_dr));
      check_eq("i_rdata", i_rdata, exp_i_rdata);
      check_eq("d_rdata", d_rdata, exp_d_rdata);

      if (er_i || er_d) begin
         txn_active = 1'b1;
         hs_cyc     = cyc;
         t_d        = er_d;
         t_addr     = er_d ? d_addr : i_addr;
         t_wstrb    = er_d ? d_wstrb : 4'h0;
         t_wdata    = d_wdata;
         t_write    = (t_wstrb != 4'h0);
         t_rdata    = t_write ? 32'h0 : ref_mem[t_addr[9:2]];
         free_at    = cyc + W + 2;
         last_d     = er_d;
         if (er_d) n_dg++;
         else      n_ig++;
      end
   endtask

   task automatic step(input logic iv, input logic [31:0] ia, input logic dv,
                       input logic [31:0] da, input logic [31:0] dw, input logic [3:0] ds);
      @(posedge clk);
      #1;
      cyc++;
      i_req_valid = iv;
      i_addr      = ia;
      d_req_valid = dv;
      d_addr      = da;
      d_wdata     = dw;
      d_wstrb     = ds;
      @(negedge clk);
      check_cycle();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   // Reset is asserted just after a rising edge, so it lands mid-cycle of whatever the DUT is doing.
   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n       = 1'b0;
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #2;
         check_eq("rst_i_ready", 32'(i_req_ready), 32'h0);
         check_eq("rst_d_ready", 32'(d_req_ready), 32'h0);
         check_eq("rst_i_resp", 32'(i_resp_valid), 32'h0);
         check_eq("rst_d_resp", 32'(d_resp_valid), 32'h0);
         check_eq("rst_i_rdata", i_rdata, 32'h0);
         check_eq("rst_d_rdata", d_rdata, 32'h0);
         check_eq("rst_mem_addr", mem_addr, 32'h0);
         check_eq("rst_mem_wdata", mem_wdata, 32'h0);
         check_eq("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
         check_eq("rst_mem_wen", 32'(mem_wen), 32'h0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      rst_n       = 1'b1;
      txn_active  = 1'b0;
      last_d      = 1'b0;
      free_at     = 0;
      exp_i_rdata = 32'h0;
      exp_d_rdata = 32'h0;
      n_ig = 0; n_dg = 0; n_conf = 0;
   endtask

   initial begin
      logic [31:0] v;
      for (int k = 0; k < 256; k++) begin
         mem[k]     = init_val(k);
         ref_mem[k] = init_val(k);
      end
      mem[64]     = 32'hDEAD_BEEF;
      ref_mem[64] = 32'hDEAD_BEEF;

      do_reset();

      // Single fetch from 0x100.
      step(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0);
      idle(W + 2);
      check_eq("fetch_data", i_rdata, 32'hDEAD_BEEF);

      // Half-word store to 0x200, then a load of the same word.
      step(1'b0, 32'h0, 1'b1, 32'h200, 32'h1234_5678, 4'b0011);
      idle(W + 1);
      check_eq("store_resp_rdata", d_rdata, 32'h0);
      step(1'b0, 32'h0, 1'b1, 32'h202, 32'hFFFF_FFFF, 4'b0000);
      idle(W + 1);
      v = init_val(128);
      check_eq("store_load", d_rdata, {v[31:16], 16'h5678});

      // Reset in the first access cycle of a write: memory must not change.
      step(1'b0, 32'h0, 1'b1, 32'h204, 32'hCAFE_F00D, 4'b1111);
      do_reset();
      idle(W + 3);
      check_eq("rst_no_write", mem[129], init_val(129));

      // Continuous conflict from reset, then two lone fetches.
      do_reset();
      for (int k = 0; k < 5 * (W + 2); k++)
         step(1'b1, 32'h100, 1'b1, 32'h108, 32'h0, 4'h0);
      idle(1);
      for (int k = 0; k < 2; k++) begin
         step(1'b1, 32'h10C, 1'b0, 32'h0, 32'h0, 4'h0);
         idle(W + 1);
      end
`ifdef MEM_ARB_PERF_EN
      check_eq("perf_conflicts_5", perf_conflicts, 32'd5);
      check_eq("perf_i_grants_4", perf_i_grants, 32'd4);
      check_eq("perf_d_grants_3", perf_d_grants, 32'd3);
`endif

      // Randomized traffic with one reset in the middle.
      for (int k = 0; k < 2500; k++) begin
         logic iv, dv;
         logic [3:0] ds;
         if (k == 1200) do_reset();
         iv = ($urandom_range(0, 99) < 60);
         dv = ($urandom_range(0, 99) < 60);
         ds = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
         step(iv, rand_addr(), dv, rand_addr(), $urandom, ds);
      end
      idle(W + 2);

      for (int k = 0; k < 256; k++) check_eq("final_mem", mem[k], ref_mem[k]);
`ifdef MEM_ARB_PERF_EN
      check_eq("perf_i_grants", perf_i_grants, 32'(n_ig));
      check_eq("perf_d_grants", perf_d_grants, 32'(n_dg));
      check_eq("perf_conflicts", perf_conflicts, 32'(n_conf));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycle=%0d got=timeout exp=finish", cyc);
      $fatal(1);
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one word-wide, combinational-read memory port between the instruction-fetch requester (I) and the load/store requester (D) of the miniRV core.
- Arbitrates round-robin and registers the request.
- Drives the memory port for a programmable number of cycles and returns a registered, single-cycle response pulse to the winner.
- Sits between the core and the ROM/RAM model, which reads combinationally and applies writes when mem_wen is high.

Parameters:
- WAIT_CYCLES, 1, cycles the memory port is held stable per access (>=1); the read is sampled on the last cycle.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_req_valid  in  1  fetch request
- i_req_ready  out  1  fetch request accepted this cycle
- i_addr  in  ADDR_W  fetch byte address
- i_resp_valid  out  1  one-cycle fetch response pulse
- i_rdata  out  32  fetched word, valid with i_resp_valid
- d_req_valid  in  1  load/store request
- d_req_ready  out  1  load/store request accepted this cycle
- d_addr  in  ADDR_W  load/store byte address
- d_wdata  in  32  store data
- d_wstrb  in  4  byte strobes; nonzero = write, zero = read
- d_resp_valid  out  1  one-cycle load/store response pulse
- d_rdata  out  32  loaded word, valid with d_resp_valid; 0 for writes
- mem_addr  out  ADDR_W  memory address, bits [1:0] forced to 0
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  memory byte strobes
- mem_wen  out  1  memory write enable
- mem_rdata  in  32  combinational memory read data

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (async, rst_n=0):
  - state=IDLE; wait counter=0; last_grant=I, so the first conflict goes to D.
  - All outputs 0; the latched addr/wdata/wstrb are cleared to 0.
- IDLE:
  - i_req_ready/d_req_ready are combinational from the valids and last_grant.
  - Only one requester is ready.
  - If exactly one is valid, that one is ready.
  - If both are valid, the one not equal to last_grant wins.
  - If neither is valid, both readies are 0.
- On handshake (valid & ready):
  - Latch addr, wdata, wstrb and the owner (wstrb forced to 0 for I).
  - Set last_grant = owner, counter = WAIT_CYCLES-1, go to ACCESS.
  - Requesters must hold their request fields stable only during the handshake cycle.
- ACCESS:
  - mem_addr/mem_wdata/mem_wstrb are driven from the latches; both readies are 0.
  - mem_wen=1 only in the final ACCESS cycle (counter==0) and only if wstrb!=0, so each write is applied exactly once.
  - Counter decrements each cycle.
  - At counter==0:
    - Register mem_rdata into the owner's rdata (0 for writes).
    - Go to RESP.
- RESP:
  - The owner's resp_valid=1 for exactly one cycle; the other resp_valid=0.
  - No response back-pressure: requesters must accept.
  - Next state is IDLE; no request is accepted in RESP.
- Latency: handshake in cycle N; ACCESS in cycles N+1..N+WAIT_CYCLES; response in cycle N+WAIT_CYCLES+1. Throughput is one access per WAIT_CYCLES+2 cycles.
- rdata holds its value until the next response to the same requester.
- mem_addr/mem_wdata/mem_wstrb hold their last values outside ACCESS; mem_wen=0 outside ACCESS.
- Unaligned address: the low 2 bits are dropped; no error is raised.
- Reset during ACCESS before the final cycle: the write is never issued and no response is produced.
- Reset during RESP: the pulse is truncated.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined:
  - Adds outputs perf_i_grants[31:0], perf_d_grants[31:0] and perf_conflicts[31:0].
  - These count I handshakes, D handshakes, and IDLE cycles with both valids high, respectively.
  - Counters wrap at 2^32 and reset to 0.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Single fetch, WAIT_CYCLES=1: mem holds 0xDEADBEEF at 0x100. i_req_valid with i_addr=0x100 in cycle 0 -> i_req_ready=1 in cycle 0; mem_addr=0x100 in cycle 1; i_resp_valid=1 and i_rdata=0xDEADBEEF in cycle 2; d_resp_valid=0 throughout.
- Store then load: d_addr=0x200, d_wdata=0x12345678, d_wstrb=4'b0011 -> mem_wen high for exactly one cycle; a subsequent load of 0x200 returns 0x????5678 with the upper bytes unchanged; the write response has d_rdata=0.
- Conflict after reset: both valids high continuously -> grants go D, I, D, I, with one response every 3 cycles (WAIT_CYCLES=1).
- WAIT_CYCLES=3 with a write -> mem_wen is asserted only in the 3rd ACCESS cycle; the response comes 4 cycles after the handshake.
- Assert rst_n=0 in the 1st ACCESS cycle of a write with WAIT_CYCLES=3 -> mem_wen is never 1, no resp_valid is produced, and the memory is unchanged.
- MEM_ARB_PERF_EN defined: after 5 conflict cycles and 2 lone fetches -> perf_conflicts=5 and grant counts match the handshakes.
